// File: rtl/evm_pkg.sv
// Shared state type and helper functions for the evm_multi voting core.
package evm_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TALLY, S_DONE} state_t;

  // Width of an index into n candidates, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic is_onehot(input logic [15:0] v);
    return $countones(v) == 1;
  endfunction

endpackage

// File: rtl/evm_tally_scan.sv
// Sequential max/tie scanner: walks one candidate tally per cycle while i_start is
// held; o_done marks the cycle in which the last candidate is folded in.
module evm_tally_scan
  import evm_pkg::*;
#(
  parameter int N_CAND = 4,
  parameter int CNT_W  = 8,
  localparam int IDX_W = idx_w(N_CAND)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [N_CAND*CNT_W-1:0] i_counts,
  output logic [IDX_W-1:0]        o_winner,
  output logic                    o_tie,
  output logic                    o_done
);

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_winner;
  logic [CNT_W-1:0] r_max;
  logic             r_tie;
  logic [CNT_W-1:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (r_idx == IDX_W'(i)) w_cnt = i_counts[i*CNT_W +: CNT_W];
    end
  end

  assign o_done   = i_start && (r_idx == IDX_W'(N_CAND - 1));
  assign o_winner = r_winner;
  assign o_tie    = r_tie;

  // Index 0 seeds the running max; later equal tallies only raise tie, so the lowest index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_max    <= '0;
      r_winner <= '0;
      r_tie    <= 1'b0;
    end else if (!i_start) begin
      r_idx <= '0;
    end else begin
      r_idx <= r_idx + 1'b1;
      if (r_idx == '0) begin
        r_max    <= w_cnt;
        r_winner <= '0;
        r_tie    <= 1'b0;
      end else if (w_cnt > r_max) begin
        r_max    <= w_cnt;
        r_winner <= r_idx;
        r_tie    <= 1'b0;
      end else if (w_cnt == r_max) begin
        r_tie <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/evm_multi.sv
// Electronic voting machine core: armed one-shot ballots, saturating tallies and a
// sequential winner scan on close. Define EVM_TIMEOUT_EN to expire idle armed ballots.
module evm_multi
  import evm_pkg::*;
#(
  parameter int N_CAND  = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16,
  localparam int IDX_W  = idx_w(N_CAND),
  localparam int TOT_W  = CNT_W + idx_w(N_CAND)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_voting_open,
  input  logic                    i_enable,
  input  logic [N_CAND-1:0]       i_vote,
  output logic                    o_ballot_ready,
  output logic                    o_vote_ack,
  output logic                    o_vote_err,
  output logic                    o_timeout,
  output logic [N_CAND*CNT_W-1:0] o_counts,
  output logic [TOT_W-1:0]        o_total,
  output logic [IDX_W-1:0]        o_winner,
  output logic                    o_tie,
  output logic                    o_result_valid
);

  state_t            r_state;
  logic              r_enable_q;
  logic [N_CAND-1:0] r_vote_q;
  logic [CNT_W-1:0]  r_cnt [N_CAND];
  logic [TOT_W-1:0]  r_total;
  logic              r_ballot_ready;
  logic              r_vote_ack;
  logic              r_vote_err;
  logic              r_result_valid;

  logic              w_enable_rise;
  logic [N_CAND-1:0] w_vote_rise;
  logic [15:0]       w_vote_ext;
  logic              w_vote_onehot;
  logic              w_vote_multi;
  logic              w_expire;
  logic              w_scan_done;

  assign w_enable_rise = i_enable & ~r_enable_q;
  assign w_vote_rise   = i_vote & ~r_vote_q;

  always_comb begin
    w_vote_ext = '0;
    w_vote_ext[N_CAND-1:0] = w_vote_rise;
  end

  assign w_vote_onehot = is_onehot(w_vote_ext);
  assign w_vote_multi  = (|w_vote_rise) && !w_vote_onehot;

  // Closing the poll takes priority over any press or expiry in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_enable_q     <= 1'b0;
      r_vote_q       <= '0;
      r_total        <= '0;
      r_ballot_ready <= 1'b0;
      r_vote_ack     <= 1'b0;
      r_vote_err     <= 1'b0;
      r_result_valid <= 1'b0;
      for (int i = 0; i < N_CAND; i++) r_cnt[i] <= '0;
    end else begin
      r_enable_q <= i_enable;
      r_vote_q   <= i_vote;
      r_vote_ack <= 1'b0;
      r_vote_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_voting_open) begin
            r_state <= S_TALLY;
          end else if (w_enable_rise) begin
            r_state        <= S_ARMED;
            r_ballot_ready <= 1'b1;
          end
        end
        S_ARMED: begin
          if (!i_voting_open) begin
            r_state        <= S_TALLY;
            r_ballot_ready <= 1'b0;
          end else if (w_vote_onehot) begin
            for (int i = 0; i < N_CAND; i++) begin
              if (w_vote_rise[i] && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
            if (r_total != '1) r_total <= r_total + 1'b1;
            r_vote_ack     <= 1'b1;
            r_ballot_ready <= 1'b0;
            r_state        <= S_IDLE;
          end else if (w_expire) begin
            r_ballot_ready <= 1'b0;
            r_state        <= S_IDLE;
          end else if (w_vote_multi) begin
            r_vote_err <= 1'b1;
          end
        end
        S_TALLY: begin
          if (w_scan_done) begin
            r_state        <= S_DONE;
            r_result_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_voting_open) begin
            r_state        <= S_IDLE;
            r_result_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef EVM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] r_timer;
  logic             r_timeout;

  assign w_expire  = (r_state == S_ARMED) && (r_timer <= TMR_W'(1));
  assign o_timeout = r_timeout;

  // Loaded on arming and never reloaded by a rejected press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire && i_voting_open && !w_vote_onehot;
      if (r_state == S_IDLE && i_voting_open && w_enable_rise) begin
        r_timer <= TMR_W'(TIMEOUT);
      end else if (r_state == S_ARMED && r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT;
  assign w_expire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  evm_tally_scan #(
    .N_CAND (N_CAND),
    .CNT_W  (CNT_W)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (r_state == S_TALLY),
    .i_counts (o_counts),
    .o_winner (o_winner),
    .o_tie    (o_tie),
    .o_done   (w_scan_done)
  );

  always_comb begin
    o_counts = '0;
    for (int i = 0; i < N_CAND; i++) o_counts[i*CNT_W +: CNT_W] = r_cnt[i];
  end

  assign o_total        = r_total;
  assign o_ballot_ready = r_ballot_ready;
  assign o_vote_ack     = r_vote_ack;
  assign o_vote_err     = r_vote_err;
  assign o_result_valid = r_result_valid;

endmodule

// File: doc/evm_multi.md
Name: evm_multi

Overview:
- Clocked, parametrised electronic voting machine core with N_CAND candidates and saturating per-candidate tallies.
- The presiding-officer `enable` arms the ballot unit for exactly one vote; a one-hot `vote` press is counted; multi-hot presses are rejected.
- When `voting_open` falls, a sequential scan computes the winner and tie flag.
- Sits between the debounced ballot-unit buttons and the display/result logic.

Parameters:
- N_CAND, 4, number of candidates (2..16)
- CNT_W, 8, width of each candidate tally
- TIMEOUT, 16, armed-ballot timeout in clk cycles (used only with EVM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- voting_open  in  1  level; 1 = poll open, 0 = poll closed
- enable  in  1  officer arm request; rising edge arms one ballot
- vote  in  N_CAND  candidate buttons, debounced, active-high
- ballot_ready  out  1  ballot armed, awaiting vote
- vote_ack  out  1  one-cycle pulse: vote counted
- vote_err  out  1  one-cycle pulse: multi-hot press rejected
- timeout  out  1  one-cycle pulse: armed ballot expired
- counts  out  N_CAND*CNT_W  tallies, candidate i at bits [i*CNT_W +: CNT_W]
- total  out  CNT_W+$clog2(N_CAND)  total votes counted
- winner  out  $clog2(N_CAND)  index of highest tally
- tie  out  1  another candidate equals the max tally
- result_valid  out  1  winner/tie valid

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - All of counts, total, winner, tie, result_valid, ballot_ready, vote_ack, vote_err and timeout are 0.
  - Edge registers (enable_q, vote_q) are cleared to 0.
- Edge detection:
  - enable_rise = enable & ~enable_q.
  - vote_rise = vote & ~vote_q.
  - Both edge registers sample every cycle in all states.
  - A button held before arming is never counted.
- States: IDLE, ARMED, TALLY, DONE.
- IDLE:
  - voting_open=1 and enable_rise -> ARMED; ballot_ready=1 from the next cycle.
  - enable_rise with voting_open=0 is ignored.
- ARMED:
  - vote_rise one-hot: next cycle the tally for that candidate increments, total increments, vote_ack=1, ballot_ready=0, state IDLE. Latency is 1 cycle.
  - vote_rise with 2 or more bits set: vote_err=1 for one cycle, no count change, stay ARMED.
  - Further enable_rise while ARMED is ignored; no double arming.
- Saturation:
  - A tally at 2^CNT_W-1 stays there, but vote_ack still pulses.
  - total saturates independently at its own maximum.
- Close:
  - voting_open=0 in IDLE or ARMED -> TALLY next cycle; ballot_ready clears.
  - Any armed ballot is discarded.
  - A vote_rise in the same cycle that voting_open falls is NOT counted; close wins.
- TALLY:
  - The scan index runs 0..N_CAND-1, one candidate per cycle, tracking max, winner and tie.
  - A strictly greater tally replaces winner and clears tie.
  - An equal tally sets tie.
  - Lowest index wins on ties.
  - After the last index -> DONE with result_valid=1, exactly N_CAND+1 cycles after voting_open falls.
- DONE:
  - Outputs hold.
  - voting_open rising -> IDLE, result_valid=0, tallies retained (cumulative); only reset clears tallies.
- All-zero tallies: winner=0, tie=1 (N_CAND>=2).
- Reset asserted mid-TALLY or mid-ARMED: immediate return to reset values; no partial result is exposed.
- vote_ack, vote_err and timeout are mutually exclusive in any cycle.

Optional Feature:
- Macro: EVM_TIMEOUT_EN.
- Defined:
  - A down-counter loads TIMEOUT on entry to ARMED.
  - If it reaches 0 with no one-hot vote, timeout=1 for one cycle, ballot_ready=0, state IDLE.
  - A vote_err does not reload the counter.
  - A valid vote on the expiry cycle takes priority; it is counted and timeout stays 0.
- Undefined: ARMED persists indefinitely; timeout is tied to 0; no counter logic is generated.

Decomposition:
- Package evm_pkg holds:
  - the state enum (IDLE, ARMED, TALLY, DONE)
  - the width function for the index and total widths
  - the onehot check function (popcount==1)
- One natural sub-module: evm_tally_scan, the sequential max/tie scanner. Inputs are start, the counts vector and N_CAND/CNT_W; outputs are winner, tie and done.

Test Plan:
- Reset, open, enable pulse, vote=0001 -> next cycle vote_ack=1, count0=1, total=1, ballot_ready=0.
- Vote=0010 without prior enable -> no count change, no ack; then enable, vote held at 0010 -> not counted until released and re-pressed.
- Armed, vote=0110 -> vote_err pulse, still ARMED; then vote=0100 -> count2 increments.
- CNT_W=2: five votes for candidate 3 -> count3=3 (saturated), total=5, five acks.
- Tallies {2,5,5,1}, drop voting_open -> result_valid exactly 5 cycles later, winner=1, tie=1; reopen -> result_valid=0, counts unchanged.
- EVM_TIMEOUT_EN, TIMEOUT=4: enable, no vote -> timeout pulse 4 cycles after arming, state IDLE; a vote on the expiry cycle -> counted, no timeout.
